// File: rtl/nixie_frame_loader.sv
// nixie_frame_loader: shifts segment frames into the IN-14 driver's two
// register banks and drives the bank-select PWM and the tube enable.
module nixie_frame_loader #(
    parameter int FRAME_W        = 72,
    parameter int DIV            = 4,
    parameter int PWM_BITS       = 8,
    parameter bit BLANK_ON_SHIFT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FRAME_W-1:0]  frame_data,
    input  logic                frame_bank,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                blank,
    output logic                busy,
    output logic                tube_clk,
    output logic                tube_data,
    output logic                tube_sel,
    output logic                tube_pwm,
    output logic                tube_en
);
    localparam int PH_W = $clog2(2 * DIV);
    localparam int BC_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [PH_W-1:0] PH_HIGH  = PH_W'(DIV);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(FRAME_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [PH_W-1:0]     ph;
    logic [PH_W-1:0]     ph_n;
    logic [BC_W-1:0]     bit_cnt;
    logic [BC_W-1:0]     bit_n;
    logic [FRAME_W-1:0]  sr;
    logic [FRAME_W-1:0]  sr_n;
    logic                sel_n;
    logic                shift_n;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_q;

    // Ready is masked by rst so it reads 0 for the whole reset window.
    assign frame_ready = (state == IDLE) & ~rst;
    assign busy        = (state == SHIFT);
    assign shift_n     = (state_n == SHIFT);

    always_comb begin
        state_n = state;
        ph_n    = ph;
        bit_n   = bit_cnt;
        sr_n    = sr;
        sel_n   = tube_sel;
        unique case (state)
            IDLE: begin
                if (frame_valid) begin
                    state_n = SHIFT;
                    ph_n    = '0;
                    bit_n   = '0;
                    sr_n    = frame_data;
                    sel_n   = frame_bank;
                end
            end
            SHIFT: begin
                if (ph == PH_LAST) begin
                    ph_n  = '0;
                    sr_n  = sr << 1;
                    bit_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = IDLE;
                    end
                end else begin
                    ph_n = ph + 1'b1;
                end
            end
        endcase
    end

    // Pin outputs are registered from next-state values so they line up
    // with the state they describe and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ph        <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            tube_sel  <= 1'b0;
            tube_clk  <= 1'b0;
            tube_data <= 1'b0;
            tube_en   <= 1'b0;
        end else begin
            state     <= state_n;
            ph        <= ph_n;
            bit_cnt   <= bit_n;
            sr        <= sr_n;
            tube_sel  <= sel_n;
            tube_clk  <= shift_n & (ph_n >= PH_HIGH);
            tube_data <= shift_n & sr_n[FRAME_W-1];
            tube_en   <= ~blank & ~(BLANK_ON_SHIFT & shift_n);
        end
    end

    // Duty is only picked up at the wrap so a period is never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            duty_q   <= '0;
            tube_pwm <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;
            tube_pwm <= (cnt < duty_q);
            if (cnt == '1) begin
                duty_q <= duty;
            end
        end
    end
endmodule

// File: tb/tb_nixie_frame_loader.sv
// tb_nixie_frame_loader: random frames and duties checked by a monitor
// against a driver-bank model and a per-period PWM high-count model.
module tb_nixie_frame_loader;
    localparam int FW        = 72;
    localparam int DIV       = 4;
    localparam int PB        = 8;
    localparam int PERIOD    = 1 << PB;
    localparam int FRAME_CYC = 2 * DIV * FW + 1;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic [FW-1:0] frame_data  = '0;
    logic          frame_bank  = 1'b0;
    logic          frame_valid = 1'b0;
    logic [PB-1:0] duty        = '0;
    logic          blank       = 1'b0;
    logic frame_ready, busy, tube_clk, tube_data, tube_sel, tube_pwm, tube_en;
    logic b_ready, b_busy, b_clk, b_data, b_sel, b_pwm, b_en;

    typedef struct {
        logic [FW-1:0] d;
        logic          b;
        int            c0;
    } fr_t;

    fr_t           q[$];
    fr_t           e;
    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    logic [FW-1:0] drv[2];
    logic [FW-1:0] expb[2];
    logic          known[2];
    int            frame_rises = 0;
    int            total_rises = 0;
    int            idle_rise   = 0;
    int            sel_bad     = 0;
    int            en_bad      = 0;
    int            en0_bad     = 0;
    int            mcnt        = 0;
    int            mduty       = 0;
    int            hi          = 0;
    logic rst_prev   = 1'b1;
    logic blank_prev = 1'b0;
    logic busy_prev  = 1'b0;
    logic clk_prev   = 1'b0;
    logic sel_prev   = 1'b0;

    nixie_frame_loader #(
        .FRAME_W(FW), .DIV(DIV), .PWM_BITS(PB), .BLANK_ON_SHIFT(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .frame_data(frame_data),
        .frame_bank(frame_bank), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .duty(duty), .blank(blank),
        .busy(busy), .tube_clk(tube_clk), .tube_data(tube_data),
        .tube_sel(tube_sel), .tube_pwm(tube_pwm), .tube_en(tube_en)
    );

    nixie_frame_loader #(
        .FRAME_W(FW), .DIV(DIV), .PWM_BITS(PB), .BLANK_ON_SHIFT(1'b0)
    ) dut_nb (
        .clk(clk), .rst(rst), .frame_data(frame_data),
        .frame_bank(frame_bank), .frame_valid(frame_valid),
        .frame_ready(b_ready), .duty(duty), .blank(blank),
        .busy(b_busy), .tube_clk(b_clk), .tube_data(b_data),
        .tube_sel(b_sel), .tube_pwm(b_pwm), .tube_en(b_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [79:0] act,
                         input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: driver-bank model, scoreboard pops, enable and PWM models.
    always @(negedge clk) begin
        if (rst_prev) begin
            if (tube_en !== 1'b0 || b_en !== 1'b0) en_bad++;
        end else begin
            if (tube_en !== (!blank_prev && !busy)) en_bad++;
            if (b_en !== !blank_prev) en0_bad++;
            if (tube_sel !== sel_prev && !(busy && !busy_prev)) sel_bad++;
        end
        if (busy && !busy_prev) frame_rises = 0;
        if (tube_clk && !clk_prev) begin
            if (!busy) idle_rise++;
            drv[tube_sel] = {drv[tube_sel][FW-2:0], tube_data};
            frame_rises++;
            total_rises++;
            if (frame_rises == 1 && q.size() != 0)
                check("first_rise", 80'(cyc - q[0].c0), 80'(1 + DIV));
        end
        if (busy_prev && rst_prev) begin
            if (q.size() != 0) begin
                e = q.pop_front();
                known[e.b] = 1'b0;
            end
        end else if (busy_prev && !busy) begin
            if (q.size() == 0) begin
                check("frame_orphan", 80'(q.size()), 80'(1));
            end else begin
                e = q.pop_front();
                expb[e.b]  = e.d;
                known[e.b] = 1'b1;
                check("frame_bits", 80'(frame_rises), 80'(FW));
                check("ready_cycle", 80'(cyc - e.c0), 80'(FRAME_CYC));
                check("ready_back", 80'(frame_ready), 80'(1));
                if (known[0]) check("bank0", 80'(drv[0]), 80'(expb[0]));
                if (known[1]) check("bank1", 80'(drv[1]), 80'(expb[1]));
                check("sel_stable", 80'(sel_bad), 80'(0));
                check("en_window", 80'(en_bad), 80'(0));
                check("en_noblank", 80'(en0_bad), 80'(0));
            end
        end
        if (rst_prev) begin
            mcnt  = 0;
            mduty = 0;
            hi    = 0;
        end
        if (tube_pwm) hi++;
        if (mcnt == PERIOD - 1) begin
            check("pwm_period", 80'(hi), 80'(mduty));
            hi    = 0;
            mduty = int'(duty);
            mcnt  = 0;
        end else begin
            mcnt++;
        end
        clk_prev   = tube_clk;
        busy_prev  = busy;
        sel_prev   = tube_sel;
        rst_prev   = rst;
        blank_prev = blank;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [FW-1:0] d, input logic b,
                        output int c);
        int n;
        frame_data  = d;
        frame_bank  = b;
        frame_valid = 1'b1;
        c = -1;
        for (n = 0; n < 2 * FRAME_CYC; n++) begin
            @(negedge clk);
            if (frame_ready) break;
        end
        if (n == 2 * FRAME_CYC) begin
            check("accept_timeout", 80'(frame_ready), 80'(1));
        end else begin
            c = cyc;
            q.push_back('{d: d, b: b, c0: cyc});
            @(posedge clk);
        end
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 2 * FRAME_CYC; n++) begin
            tick();
            if (!busy && frame_ready) break;
        end
        if (n == 2 * FRAME_CYC)
            check("idle_timeout", 80'({busy, frame_ready}), 80'(1));
    endtask

    function automatic logic [FW-1:0] rnd_frame();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[FW-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, r0, n;
        drv[0] = '0;
        drv[1] = '0;
        expb[0] = '0;
        expb[1] = '0;
        known[0] = 1'b1;
        known[1] = 1'b1;

        tick();
        check("reset_outs", 80'({frame_ready, busy, tube_clk, tube_data,
              tube_sel, tube_pwm, tube_en}), 80'(0));
        tick();
        check("reset_outs2", 80'({frame_ready, busy, tube_clk, tube_data,
              tube_sel, tube_pwm, tube_en}), 80'(0));
        tick();
        rst = 1'b0;
        #1;
        check("ready_release", 80'({frame_ready, tube_en}), 80'(2'b10));
        tick();
        check("en_release", 80'({tube_en, b_en}), 80'(2'b11));

        r0 = total_rises;
        send(72'hA5_0123_4567_89AB_CDEF, 1'b1, c0);
        tick();
        check("en_shift", 80'({busy, tube_en, tube_sel}), 80'(3'b101));
        wait_idle();
        check("single_rises", 80'(total_rises - r0), 80'(FW));

        r0 = total_rises;
        send(rnd_frame(), 1'b0, c0);
        send(rnd_frame(), 1'b1, c1);
        check("b2b_gap", 80'(c1 - c0), 80'(FRAME_CYC));
        wait_idle();
        check("b2b_rises", 80'(total_rises - r0), 80'(2 * FW));

        for (int i = 0; i < 3; i++) begin
            duty = PB'($urandom_range(0, PERIOD - 1));
            send(rnd_frame(), 1'($urandom_range(0, 1)), c0);
            wait_idle();
        end

        duty = 8'd64;
        repeat (2 * PERIOD + 10) tick();
        for (n = 0; n < PERIOD && mcnt != 100; n++) tick();
        duty = 8'd200;
        repeat (3 * PERIOD) tick();
        duty = 8'd0;
        repeat (3 * PERIOD) tick();
        duty = 8'hFF;
        repeat (2 * PERIOD) tick();

        send(rnd_frame(), 1'b0, c0);
        for (n = 0; n < FRAME_CYC && frame_rises < 30; n++) tick();
        rst = 1'b1;
        tick();
        check("abort_outs", 80'({tube_clk, busy, frame_ready}), 80'(0));
        rst = 1'b0;
        r0 = total_rises;
        repeat (40) tick();
        check("abort_quiet", 80'(total_rises - r0), 80'(0));
        send(rnd_frame(), 1'b0, c0);
        wait_idle();

        blank = 1'b1;
        tick();
        check("blank_idle", 80'({tube_en, b_en}), 80'(0));
        blank = 1'b0;
        tick();
        check("unblank_idle", 80'({tube_en, b_en}), 80'(2'b11));
        send(rnd_frame(), 1'b1, c0);
        repeat (20) tick();
        check("noblank_shift", 80'({busy, tube_en, b_en}), 80'(3'b101));
        blank = 1'b1;
        tick();
        check("blank_shift", 80'({busy, b_en}), 80'(2'b10));
        blank = 1'b0;
        tick();
        check("unblank_shift", 80'({busy, b_en}), 80'(2'b11));
        wait_idle();
        check("en_after", 80'(tube_en), 80'(1));

        repeat (5) tick();
        check("queue_empty", 80'(q.size()), 80'(0));
        check("idle_edges", 80'(idle_rise), 80'(0));
        check("sel_total", 80'(sel_bad), 80'(0));
        check("en_total", 80'({en_bad, en0_bad}), 80'(0));
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/nixie_frame_loader.md
# nixie_frame_loader

Sequencer that feeds the IN-14 tube driver CPLD's dual 72-bit shift-register banks and drives its bank-select and enable pins. It accepts whole 72-bit segment frames over a valid/ready handshake and serializes them MSB-first onto the driver's shift clock, data and bank-select lines. It generates the bank-select PWM that alternates the displayed bank, giving dimming and crossfade between two frames, and gates tube enable. It sits between the clock firmware/register interface and the driver pins.

## Interface
- FRAME_W, 72: bits per frame; must equal the driver chain length.
- DIV, 4: system clocks per half period of tube_clk; legal values are 1 and above.
- PWM_BITS, 8: width of the PWM counter and of duty.
- BLANK_ON_SHIFT, 1: when 1, tube_en is forced low while a frame is shifting.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- frame_data  in  FRAME_W  frame to load; bit FRAME_W-1 is shifted first.
- frame_bank  in  1  target bank. 1 loads the bank shown while tube_pwm=1; 0 loads the bank shown while tube_pwm=0.
- frame_valid  in  1  request to load a frame.
- frame_ready  out  1  loader idle; a frame is accepted on any edge where valid and ready are both high.
- duty  in  PWM_BITS  number of counter steps per PWM period that bank 1 is displayed.
- blank  in  1  when 1, forces the tubes off.
- busy  out  1  a frame is shifting.
- tube_clk  out  1  driver shift clock.
- tube_data  out  1  driver serial data.
- tube_sel  out  1  driver bank select for shifting.
- tube_pwm  out  1  driver displayed-bank select.
- tube_en  out  1  driver output enable.

## Operation
- There are two states: IDLE and SHIFT.
- **IDLE**
  - frame_ready=1, busy=0, tube_clk=0, tube_data=0.
  - tube_sel holds its last value.
  - On accept, the block latches frame_data into an internal shift register, drives tube_sel=frame_bank, sets the bit counter to 0, clears the phase counter, and goes to SHIFT.
- **SHIFT**
  - frame_ready=0, busy=1.
  - Each bit has a low phase of DIV cycles (tube_clk=0) followed by a high phase of DIV cycles (tube_clk=1).
  - tube_data is the current MSB of the shift register. It changes only at the start of a low phase, which gives DIV cycles of setup and DIV cycles of hold around each tube_clk rising edge.
  - At the end of each high phase, the register shifts left by 1 and the bit counter increments.
  - After bit FRAME_W-1 completes its high phase, the block returns to IDLE.
- tube_sel is constant for the whole frame and is valid before the first tube_clk rise.
- A valid request while busy is not accepted. The requester must keep frame_valid asserted; frame_data is sampled only at accept.
- **PWM**
  - A free-running PWM_BITS counter cnt increments every clk and wraps from all-ones to 0.
  - tube_pwm = (cnt < duty_q).
  - duty_q loads from duty only on the cycle cnt wraps to 0, so a change to duty takes effect at the next period boundary and periods never glitch.
  - duty=0 displays bank 0 only. duty=2^PWM_BITS-1 displays bank 1 for 255 of 256 steps.
- **Enable**
  - tube_en = registered (~blank & ~(BLANK_ON_SHIFT & busy_next)).
  - The blanking window covers exactly the SHIFT state.
- **Reset**
  - All outputs take their reset values: tube_clk=0, tube_data=0, tube_sel=0, tube_pwm=0, tube_en=0, busy=0, frame_ready=0.
  - cnt=0, duty_q=0, state=IDLE.
  - Reset mid-frame aborts immediately. The partial frame left in the driver is not repaired; the firmware must reload.
  - frame_ready goes to 1 on the first cycle after rst deasserts.

## Timing
- Cycle 0 is the accept edge. In cycle 1, tube_clk=0, tube_data=frame_data[FRAME_W-1] and tube_sel=frame_bank.
- tube_clk for bit k:
  - falls at cycle 1+2·DIV·k;
  - rises at cycle 1+DIV·(2k+1).
- The last high phase ends at cycle 2·DIV·FRAME_W. frame_ready=1 from cycle 2·DIV·FRAME_W+1, which is 577 with the defaults.
- The earliest back-to-back accept is at that same cycle, giving a throughput of one frame per 2·DIV·FRAME_W+1 cycles.
- tube_en follows blank with a latency of 1 cycle.
- tube_pwm is registered, 1 cycle after cnt.
- The PWM period is 2^PWM_BITS cycles.
- Exactly FRAME_W rising edges of tube_clk occur per frame. There are no edges in IDLE or during reset.

## Test plan
- **Reset:** assert rst for 3 cycles with blank=0. All outputs are 0 during reset. frame_ready=1 at the first cycle after release. tube_en=1 one cycle later.
- **Single frame:** frame_data=72'hA5_0123_4567_89AB_CDEF, bank=1, DIV=4. The bench model captures 72 bits on tube_clk rises; the captured data1 equals the frame and data2 is unchanged. frame_ready returns at cycle 577. tube_en=0 throughout SHIFT.
- **Back-to-back frames:** hold valid high with bank 0, then bank 1. Exactly 144 tube_clk rises total. tube_sel switches only in the IDLE/accept cycle. The second accept occurs at cycle 577.
- **PWM:** duty=64. tube_pwm is high for exactly 64 of every 256 cycles. Changing duty to 200 mid-period does not affect the current period; the next period has 200 high cycles. duty=0 gives tube_pwm constantly 0.
- **Reset mid-shift:** assert rst after 30 tube_clk rises. tube_clk=0 and busy=0 on the next cycle. No further edges occur. A new frame then loads correctly.
- **Blank and BLANK_ON_SHIFT=0:** blank=1 gives tube_en=0 one cycle later regardless of state. With BLANK_ON_SHIFT=0 and blank=0, tube_en stays 1 throughout a shift.
